route_hop_forwarder: RTL and testbench
======================================

# route_hop_forwarder

Per-hop packet forwarding stage placed downstream of the combinational XY route-decision logic in the mesh router. It accepts wormhole packets (head/body/tail flits) on one input channel and steers each packet to the X, Y or local output channel named by the route decision sampled with the head flit. It rewrites the head flit's signed destination offsets for the next hop, holding the port lock until the tail flit. It provides a one-deep registered output stage with valid/ready backpressure and counts packets dropped for illegal route decisions.

## Interface
- `DATA_W`, default 64: payload width per flit.
- `OFS_W`, default 30: width of `dest_x`/`dest_y` offsets, two's complement.
- `CNT_W`, default 16: drop-counter width.

Ports:
- `clk` input 1: single clock, all logic rising-edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: input flit valid.
- `in_ready` output 1: input flit accepted when `in_valid & in_ready`.
- `in_head`, `in_tail` input 1 each: flit framing. Both high means a single-flit packet.
- `in_data` input DATA_W: payload.
- `in_dest_x`, `in_dest_y` input OFS_W: signed hop offsets. Meaningful on head flits only.
- `route_port` input 3: route decision for the head flit. Bit 0 = X, bit 1 = Y, bit 2 = local. Must be one-hot.
- `out_valid` output 3: one-hot per-port valid.
- `out_ready` input 3: per-port ready.
- `out_head`, `out_tail` output 1 each.
- `out_data` output DATA_W.
- `out_dest_x`, `out_dest_y` output OFS_W: rewritten offsets. Zero on non-head flits.
- `drop_cnt` output CNT_W: dropped-packet count. Saturates at all-ones.

## Operation
- FSM states: IDLE, FWD, DROP.
- IDLE:
  - Accepted head flit with one-hot `route_port`: latch the port into `lock_port`, load the flit into the output stage, go to FWD. Go to IDLE instead if `in_tail` is also high.
  - Accepted head flit with `route_port` not one-hot (including 000): discard the flit and increment `drop_cnt`. Go to DROP, or stay in IDLE if `in_tail` is high.
  - Accepted non-head flit (orphan): discard silently, no count.
- FWD:
  - Every accepted flit goes to `lock_port`. `in_head` is ignored and the flit is treated as body; `out_head` is forced to 0 and the destination outputs to 0.
  - Accepted tail returns the FSM to IDLE.
- DROP: every accepted flit is discarded. Accepted tail returns to IDLE.
- Offset rewrite, applied on head flits only:
  - Port X: `dest_x` moves one step toward zero (positive −1, negative +1, zero unchanged). `dest_y` unchanged.
  - Port Y: same rule applied to `dest_y`; `dest_x` unchanged.
  - Local: both offsets unchanged.
  - Arithmetic is OFS_W-bit and cannot overflow, because the step is always toward zero.
- Output stage: one register holding valid, flit fields and port.
  - `out_valid = stage_valid ? stage_port : 3'b000`.
  - Stage drains when `out_ready[stage_port]` is high.
- `in_ready = ~stage_valid | out_ready[stage_port]` in IDLE/FWD. This gives full throughput with a combinational ready pass-through.
- `in_ready = 1` in DROP.
- `in_ready = 1` in IDLE while the stage is empty, so orphans and illegal heads are always consumed.
- `out_ready` bits of non-selected ports are ignored.

## Timing
- Latency: a flit accepted in cycle N appears on the outputs in cycle N+1.
- Throughput: 1 flit/cycle while the selected `out_ready` stays high.
- Output stability: once `out_valid` is high, `out_valid` and all `out_*` fields hold stable until the handshake completes.
- Same-cycle drain and load: the stage drains and reloads in the same cycle without a bubble.
- Back-to-back packets: the tail of packet A and the head of packet B may be accepted on consecutive cycles. B may target a different port; its `out_valid` moves to the new port one cycle after its head is accepted.
- Reset values: FSM = IDLE, `stage_valid` = 0, `out_valid` = 000, `out_head` = `out_tail` = 0, `out_data` = 0, `out_dest_x` = `out_dest_y` = 0, `drop_cnt` = 0, `in_ready` = 1 (from the first cycle after reset).
- Reset mid-packet: the in-flight stage flit is lost and the FSM returns to IDLE. Flits of the interrupted packet arriving afterwards are orphans and are discarded.
- `drop_cnt` updates in the cycle after the illegal head is accepted. At all-ones it holds.

## Test plan
- Single-flit packet: head+tail, `dest_x`=5, `dest_y`=−3, `route_port`=001 → next cycle `out_valid`=001, `out_dest_x`=4, `out_dest_y`=−3, `out_head`=`out_tail`=1; FSM ends in IDLE.
- 4-flit packet to Y with `dest_y`=−1 and `out_ready[1]` toggling 1,0,1,0… → flits emerge in order on port 1 only. Head carries `dest_y`=0. `out_*` held stable across stall cycles. `route_port` changes on body flits have no effect.
- Illegal route 011 on a 3-flit packet, then a legal local packet → all 3 flits consumed with `in_ready`=1 and no `out_valid`. `drop_cnt`=1. Local packet delivered on port 2 with offsets unchanged.
- Orphan body flit in IDLE, then `drop_cnt` preset to 0xFFFF via 65535 illegal single-flit heads plus one more → orphan discarded; `drop_cnt` stays 0xFFFF.
- Back-to-back: X packet tail followed immediately by Y packet head, all `out_ready`=111 → no bubble, `out_valid` goes 001→010 on the next cycle.
- Reset asserted mid-packet while the stage holds a flit → next cycle `out_valid`=000 and `in_ready`=1. Remaining body/tail flits are discarded; `drop_cnt` unchanged.

Source files
------------

// File: rtl/route_hop_forwarder.sv
// route_hop_forwarder: steers wormhole packets to X/Y/local via a one-deep output stage,
// rewriting head offsets for the next hop and counting packets dropped for bad routes.
module route_hop_forwarder #(
    parameter int DATA_W = 64,
    parameter int OFS_W  = 30,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_head,
    input  logic              in_tail,
    input  logic [DATA_W-1:0] in_data,
    input  logic [OFS_W-1:0]  in_dest_x,
    input  logic [OFS_W-1:0]  in_dest_y,
    input  logic [2:0]        route_port,
    output logic [2:0]        out_valid,
    input  logic [2:0]        out_ready,
    output logic              out_head,
    output logic              out_tail,
    output logic [DATA_W-1:0] out_data,
    output logic [OFS_W-1:0]  out_dest_x,
    output logic [OFS_W-1:0]  out_dest_y,
    output logic [CNT_W-1:0]  drop_cnt
);
    typedef enum logic [1:0] {IDLE, FWD, DROP} state_t;
    state_t              state_q;
    logic [2:0]          lock_q, port_q;
    logic                valid_q, head_q, tail_q;
    logic [DATA_W-1:0]   data_q;
    logic [OFS_W-1:0]    dx_q, dy_q, dx_d, dy_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                drain, acc, legal, load_head, load_body;

    function automatic logic [OFS_W-1:0] step(input logic [OFS_W-1:0] v);
        return v == '0 ? v : v[OFS_W-1] ? v + OFS_W'(1) : v - OFS_W'(1);
    endfunction

    assign drain     = valid_q & |(out_ready & port_q);
    assign in_ready  = (state_q == DROP) | ~valid_q | drain;
    assign acc       = in_valid & in_ready;
    assign legal     = route_port == 3'b001 || route_port == 3'b010 || route_port == 3'b100;
    assign load_head = acc & (state_q == IDLE) & in_head & legal;
    assign load_body = acc & (state_q == FWD);
    assign dx_d      = route_port[0] ? step(in_dest_x) : in_dest_x;
    assign dy_d      = route_port[1] ? step(in_dest_y) : in_dest_y;
    assign cnt_d     = &cnt_q ? cnt_q : cnt_q + CNT_W'(1);

    assign out_valid  = valid_q ? port_q : 3'b000;
    assign out_head   = head_q;
    assign out_tail   = tail_q;
    assign out_data   = data_q;
    assign out_dest_x = dx_q;
    assign out_dest_y = dy_q;
    assign drop_cnt   = cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            lock_q  <= '0;
            port_q  <= '0;
            valid_q <= 1'b0;
            head_q  <= 1'b0;
            tail_q  <= 1'b0;
            data_q  <= '0;
            dx_q    <= '0;
            dy_q    <= '0;
            cnt_q   <= '0;
        end else begin
            if (load_head | load_body) begin
                valid_q <= 1'b1;
                head_q  <= load_head;
                tail_q  <= in_tail;
                data_q  <= in_data;
                dx_q    <= load_head ? dx_d : '0;
                dy_q    <= load_head ? dy_d : '0;
                port_q  <= load_head ? route_port : lock_q;
            end else if (drain) begin
                valid_q <= 1'b0;
            end
            // body flits always follow the locked port, whatever route_port says
            if (acc) begin
                case (state_q)
                    IDLE: if (in_head) begin
                        if (legal) begin
                            lock_q  <= route_port;
                            state_q <= in_tail ? IDLE : FWD;
                        end else begin
                            cnt_q   <= cnt_d;
                            state_q <= in_tail ? IDLE : DROP;
                        end
                    end
                    FWD, DROP: if (in_tail) state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_route_hop_forwarder.sv
// tb_route_hop_forwarder: randomized + directed bench; packet-level model feeds a scoreboard
// queue that an independent output monitor drains.
module tb_route_hop_forwarder;
    localparam int DW = 64;
    localparam int OW = 30;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0, in_ready, in_head = 1'b0, in_tail = 1'b0;
    logic [DW-1:0] in_data = '0;
    logic [OW-1:0] in_dest_x = '0, in_dest_y = '0;
    logic [2:0]    route_port = '0, out_valid, out_ready = '0;
    logic          out_head, out_tail;
    logic [DW-1:0] out_data;
    logic [OW-1:0] out_dest_x, out_dest_y;
    logic [CW-1:0] drop_cnt;

    always #5 clk = ~clk;

    route_hop_forwarder #(.DATA_W(DW), .OFS_W(OW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_head(in_head), .in_tail(in_tail), .in_data(in_data),
        .in_dest_x(in_dest_x), .in_dest_y(in_dest_y), .route_port(route_port),
        .out_valid(out_valid), .out_ready(out_ready), .out_head(out_head),
        .out_tail(out_tail), .out_data(out_data), .out_dest_x(out_dest_x),
        .out_dest_y(out_dest_y), .drop_cnt(drop_cnt)
    );

    typedef struct {
        logic [2:0]    port;
        logic          head, tail;
        logic [DW-1:0] data;
        logic [OW-1:0] dx, dy;
    } exp_t;

    exp_t          exp_q[$];
    int            checks = 0, fails = 0;
    int            mode = 0;
    logic [2:0]    lock = '0;
    logic [CW-1:0] cnt = '0;
    int            rmode = 1;
    logic          tog = 1'b0;

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [OW-1:0] step(input logic [OW-1:0] v);
        int s;
        s = $signed(v);
        if (s > 0) s--;
        else if (s < 0) s++;
        return s[OW-1:0];
    endfunction

    task automatic model_accept(input logic h, t, input logic [DW-1:0] d,
                                input logic [OW-1:0] dx, dy, input logic [2:0] rp);
        exp_t e;
        if (mode == 0) begin
            if (h) begin
                if ($countones(rp) == 1) begin
                    e.port = rp; e.head = 1'b1; e.tail = t; e.data = d;
                    e.dx = rp == 3'b001 ? step(dx) : dx;
                    e.dy = rp == 3'b010 ? step(dy) : dy;
                    exp_q.push_back(e);
                    lock = rp;
                    mode = t ? 0 : 1;
                end else begin
                    if (cnt != '1) cnt++;
                    mode = t ? 0 : 2;
                end
            end
        end else if (mode == 1) begin
            e.port = lock; e.head = 1'b0; e.tail = t; e.data = d; e.dx = '0; e.dy = '0;
            exp_q.push_back(e);
            if (t) mode = 0;
        end else if (t) begin
            mode = 0;
        end
    endtask

    // called at posedge+1; returns at posedge+1 after the flit is taken
    task automatic send(input logic h, t, input logic [DW-1:0] d,
                        input logic [OW-1:0] dx, dy, input logic [2:0] rp);
        int n = 0;
        in_valid = 1'b1; in_head = h; in_tail = t; in_data = d;
        in_dest_x = dx; in_dest_y = dy; route_port = rp;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++; fails++;
            $display("FAIL send_timeout: in_ready stuck 0, required 1 within 200 cycles");
            @(posedge clk); #1 in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        model_accept(h, t, d, dx, dy, rp);
        #1 in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drain_wait();
        int n = 0;
        rmode = 1;
        while (exp_q.size() != 0 && n < 100) begin n++; idle(1); end
        idle(2);
        chk("drain_empty", exp_q.size(), 0);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        exp_q.delete(); mode = 0; cnt = '0;
        #1 rst = 1'b0;
    endtask

    function automatic logic [OW-1:0] rdest();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return OW'(1);
            2: return '1;
            3: return {1'b1, {(OW-1){1'b0}}};
            4: return {1'b0, {(OW-1){1'b1}}};
            default: return OW'($urandom);
        endcase
    endfunction

    function automatic logic [DW-1:0] rdata();
        return {$urandom, $urandom};
    endfunction

    always @(posedge clk) begin
        #1;
        case (rmode)
            0: out_ready = 3'($urandom);
            1: out_ready = 3'b111;
            2: begin tog = ~tog; out_ready = {1'($urandom), tog, 1'($urandom)}; end
            default: out_ready = 3'b000;
        endcase
    end

    // output monitor: pops on each handshake and checks hold-while-stalled
    logic [128:0] snap, prev;
    logic         have_prev = 1'b0, hs;
    always @(negedge clk) begin
        if (rst) begin
            have_prev = 1'b0;
        end else begin
            chk("drop_cnt", drop_cnt, cnt);
            snap = {out_valid, out_head, out_tail, out_data, out_dest_x, out_dest_y};
            if (have_prev) chk("hold_stable", snap, prev);
            chk("valid_onehot0", $countones(out_valid) <= 1, 1);
            hs = |(out_valid & out_ready);
            if (hs) begin
                if (exp_q.size() == 0) begin
                    checks++; fails++;
                    $display("FAIL unexpected_flit: got %0h expected none", snap);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("flit", snap, {e.port, e.head, e.tail, e.data, e.dx, e.dy});
                end
            end
            have_prev = (out_valid != 3'b000) && !hs;
            prev = snap;
        end
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        exp_q.delete(); mode = 0; cnt = '0;
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", out_valid, 3'b000);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_head_tail", {out_head, out_tail}, 2'b00);
        chk("rst_data", out_data, 0);
        chk("rst_dest", {out_dest_x, out_dest_y}, 0);
        chk("rst_drop_cnt", drop_cnt, 0);
        @(posedge clk); #1;

        // single-flit packet to X
        send(1'b1, 1'b1, 64'hA5A5_0000_1234_5678, OW'(5), OW'(-3), 3'b001);
        @(negedge clk);
        chk("sf_valid", out_valid, 3'b001);
        chk("sf_dest", {out_dest_x, out_dest_y}, {OW'(4), OW'(-3)});
        chk("sf_head_tail", {out_head, out_tail}, 2'b11);
        @(posedge clk); #1;
        drain_wait();

        // 4-flit packet to Y under toggling ready; body route_port is noise
        rmode = 2;
        send(1'b1, 1'b0, rdata(), OW'(7), OW'(-1), 3'b010);
        send(1'b0, 1'b0, rdata(), rdest(), rdest(), 3'b001);
        send(1'b1, 1'b0, rdata(), rdest(), rdest(), 3'b100);
        send(1'b0, 1'b1, rdata(), rdest(), rdest(), 3'b111);
        drain_wait();

        // illegal route then a legal local packet
        fork
            begin
                send(1'b1, 1'b0, rdata(), OW'(3), OW'(3), 3'b011);
                send(1'b0, 1'b0, rdata(), '0, '0, 3'b001);
                send(1'b0, 1'b1, rdata(), '0, '0, 3'b010);
            end
            repeat (3) begin
                @(negedge clk);
                chk("drop_in_ready", in_ready, 1);
                chk("drop_no_valid", out_valid, 3'b000);
            end
        join
        @(negedge clk);
        chk("drop_cnt_one", drop_cnt, 1);
        @(posedge clk); #1;
        send(1'b1, 1'b0, rdata(), OW'(9), OW'(-9), 3'b100);
        send(1'b0, 1'b1, rdata(), '0, '0, 3'b000);
        drain_wait();

        // back-to-back X then Y
        send(1'b1, 1'b0, rdata(), OW'(2), OW'(2), 3'b001);
        send(1'b0, 1'b1, rdata(), '0, '0, 3'b001);
        fork
            send(1'b1, 1'b1, rdata(), OW'(1), OW'(-2), 3'b010);
            begin
                @(negedge clk); chk("b2b_x", out_valid, 3'b001);
                @(negedge clk); chk("b2b_y", out_valid, 3'b010);
            end
        join
        drain_wait();

        // reset while the stage holds a flit
        rmode = 3;
        idle(2);
        send(1'b1, 1'b0, rdata(), OW'(4), OW'(4), 3'b001);
        do_reset();
        @(negedge clk);
        chk("mid_rst_valid", out_valid, 3'b000);
        chk("mid_rst_ready", in_ready, 1);
        @(posedge clk); #1;
        send(1'b0, 1'b0, rdata(), '0, '0, 3'b001);
        send(1'b0, 1'b1, rdata(), '0, '0, 3'b001);
        drain_wait();
        chk("mid_rst_cnt", drop_cnt, 0);

        // randomized traffic
        rmode = 0;
        for (int p = 0; p < 1200; p++) begin
            int len, kind;
            logic [2:0] rp;
            logic [2:0] bad[5] = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};
            len  = $urandom_range(1, 4);
            kind = $urandom_range(0, 9);
            rp   = kind < 8 ? 3'(1 << $urandom_range(0, 2)) : bad[$urandom_range(0, 4)];
            if (kind == 9) send(1'b0, 1'($urandom), rdata(), rdest(), rdest(), 3'($urandom));
            for (int f = 0; f < len; f++) begin
                send(f == 0, f == len - 1, rdata(), rdest(), rdest(), f == 0 ? rp : 3'($urandom));
                if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
            end
        end
        drain_wait();

        // saturate the drop counter, then an orphan
        while (cnt != '1) send(1'b1, 1'b1, rdata(), rdest(), rdest(), 3'b000);
        send(1'b1, 1'b1, rdata(), rdest(), rdest(), 3'b110);
        send(1'b0, 1'b1, rdata(), rdest(), rdest(), 3'b001);
        idle(2);
        @(negedge clk);
        chk("sat_cnt", drop_cnt, 16'hFFFF);
        chk("sat_no_valid", out_valid, 3'b000);
        @(posedge clk); #1;
        drain_wait();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
